// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between instruction fetch (F) and the
// load/store path (L). One access is granted per cycle; in-flight reads are
// tracked through a RD_LATENCY-deep {valid, owner} pipeline so the returning
// ram_rdata is routed to the requester that issued it.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   f_req/f_addr -> f_gnt             fetch read request / accept
//   f_rvalid/f_rdata                  fetch read return
//   f_flush                           drop all in-flight fetch reads
//   l_req/l_we/l_addr/l_wdata -> l_gnt load/store request / accept
//   l_rvalid/l_rdata                  load read return
//   ram_en/ram_we/ram_addr/ram_wdata  RAM request side
//   ram_rdata                         RAM read data, RD_LATENCY after strobe
//   busy                              any read in flight
module mem_port_arbiter #(
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned MAX_L_STREAK = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        f_flush,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic        l_rvalid,
  output logic [31:0] l_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  output logic        busy
);

  localparam int unsigned STREAK_W = 4;
  localparam int unsigned DEPTH    = RD_LATENCY;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_L_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [DEPTH-1:0]    pipe_v_q, pipe_v_d;   // entry holds a live read
  logic [DEPTH-1:0]    pipe_f_q, pipe_f_d;   // entry owner: 1 = F, 0 = L
  logic                f_win;
  logic                out_v;
  logic                out_f;

  // Arbitration and RAM request mux; grants are forced low during reset.
  always_comb begin
    f_gnt     = 1'b0;
    l_gnt     = 1'b0;
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    f_win     = f_req && (!l_req || (streak_q == STREAK_MAX));
    if (reset_n) begin
      f_gnt = f_win;
      l_gnt = l_req && !f_win;
    end
    ram_en = f_gnt | l_gnt;
    if (f_gnt) begin
      ram_addr = f_addr;
    end else if (l_gnt) begin
      ram_we    = l_we;
      ram_addr  = l_addr;
      ram_wdata = l_wdata;
    end
  end

  // Consecutive-L counter: only counts L wins while F is actually waiting.
  always_comb begin
    streak_d = '0;
    if (l_gnt && f_req) begin
      streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + STREAK_W'(1);
    end
  end

  // In-flight pipeline; a flush kills F entries as they move, while the new
  // stage-0 entry (the post-redirect fetch) is always kept.
  always_comb begin
    pipe_v_d    = '0;
    pipe_f_d    = '0;
    pipe_v_d[0] = f_gnt || (l_gnt && !l_we);
    pipe_f_d[0] = f_gnt;
    for (int i = 1; i < int'(DEPTH); i++) begin
      pipe_v_d[i] = pipe_v_q[i-1] && !(f_flush && pipe_f_q[i-1]);
      pipe_f_d[i] = pipe_f_q[i-1];
    end
  end

  // Return routing from the output stage; non-owner data is held at zero.
  always_comb begin
    out_v    = pipe_v_q[DEPTH-1];
    out_f    = pipe_f_q[DEPTH-1];
    f_rvalid = out_v && out_f && !f_flush;
    l_rvalid = out_v && !out_f;
    f_rdata  = f_rvalid ? ram_rdata : '0;
    l_rdata  = l_rvalid ? ram_rdata : '0;
    busy     = |pipe_v_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      streak_q <= '0;
      pipe_v_q <= '0;
      pipe_f_q <= '0;
    end else begin
      streak_q <= streak_d;
      pipe_v_q <= pipe_v_d;
      pipe_f_q <= pipe_f_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed + random stimulus for mem_port_arbiter with a
// transaction-level reference model (queue of pending reads with due cycles)
// and a simple fixed-latency RAM responder.
module tb_mem_port_arbiter;

  localparam int unsigned LAT  = 3;
  localparam int unsigned MAXS = 4;

  logic        clk;
  logic        reset_n;
  logic        f_req, f_flush, l_req, l_we;
  logic [31:0] f_addr, l_addr, l_wdata;
  logic        f_gnt, f_rvalid, l_gnt, l_rvalid;
  logic [31:0] f_rdata, l_rdata;
  logic        ram_en, ram_we, busy;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  mem_port_arbiter #(.RD_LATENCY(LAT), .MAX_L_STREAK(MAXS)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_flush(f_flush),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  // RAM responder: returns mem_fn(addr) LAT cycles after a read strobe.
  bit          rp_v [LAT];
  logic [31:0] rp_a [LAT];
  logic [31:0] junk = 32'h5A5A_A5A5;
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      rp_v[i] <= rp_v[i-1];
      rp_a[i] <= rp_a[i-1];
    end
    rp_v[0] <= ram_en && !ram_we;
    rp_a[0] <= ram_addr;
    junk    <= $urandom;
  end
  assign ram_rdata = rp_v[LAT-1] ? mem_fn(rp_a[LAT-1]) : junk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: pending reads as {owner, addr, due cycle}.
  typedef struct {
    bit          own_f;
    logic [31:0] addr;
    int          due;
  } ent_t;

  ent_t q[$];
  int   streak = 0;
  int   cyc = 0;
  bit   last_fg, last_lg;

  task automatic model_check();
    bit          efg, elg, ewe, frv, lrv;
    logic [31:0] eaddr, ewd, frd, lrd;
    ent_t        nq[$];
    efg   = f_req && (!l_req || streak == int'(MAXS));
    elg   = l_req && !efg;
    ewe   = elg && l_we;
    eaddr = efg ? f_addr : (elg ? l_addr : 32'h0);
    ewd   = elg ? l_wdata : 32'h0;
    frv = 1'b0; lrv = 1'b0; frd = 32'h0; lrd = 32'h0;
    foreach (q[i]) begin
      if (q[i].due == cyc) begin
        if (q[i].own_f && !f_flush) begin frv = 1'b1; frd = mem_fn(q[i].addr); end
        if (!q[i].own_f) begin lrv = 1'b1; lrd = mem_fn(q[i].addr); end
      end
    end
    chk("f_gnt", 32'(f_gnt), 32'(efg));
    chk("l_gnt", 32'(l_gnt), 32'(elg));
    chk("ram_en", 32'(ram_en), 32'(efg | elg));
    chk("ram_we", 32'(ram_we), 32'(ewe));
    chk("ram_addr", ram_addr, eaddr);
    chk("ram_wdata", ram_wdata, ewd);
    chk("f_rvalid", 32'(f_rvalid), 32'(frv));
    chk("f_rdata", f_rdata, frd);
    chk("l_rvalid", 32'(l_rvalid), 32'(lrv));
    chk("l_rdata", l_rdata, lrd);
    chk("busy", 32'(busy), 32'(q.size() != 0));
    foreach (q[i]) begin
      if (q[i].due != cyc && !(f_flush && q[i].own_f)) nq.push_back(q[i]);
    end
    q = nq;
    if (efg) q.push_back('{own_f: 1'b1, addr: f_addr, due: cyc + int'(LAT)});
    if (elg && !l_we) q.push_back('{own_f: 1'b0, addr: l_addr, due: cyc + int'(LAT)});
    if (elg && f_req) streak = (streak < int'(MAXS)) ? streak + 1 : streak;
    else streak = 0;
    last_fg = efg;
    last_lg = elg;
    cyc++;
  endtask

  task automatic drive(input logic fr, input logic [31:0] fa, input logic fl,
                       input logic lr, input logic lwe, input logic [31:0] la,
                       input logic [31:0] lwd);
    f_req = fr; f_addr = fa; f_flush = fl;
    l_req = lr; l_we = lwe; l_addr = la; l_wdata = lwd;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_f_gnt"}, 32'(f_gnt), 32'h0);
    chk({tag, "_l_gnt"}, 32'(l_gnt), 32'h0);
    chk({tag, "_f_rvalid"}, 32'(f_rvalid), 32'h0);
    chk({tag, "_f_rdata"}, f_rdata, 32'h0);
    chk({tag, "_l_rvalid"}, 32'(l_rvalid), 32'h0);
    chk({tag, "_l_rdata"}, l_rdata, 32'h0);
    chk({tag, "_ram_en"}, 32'(ram_en), 32'h0);
    chk({tag, "_ram_we"}, 32'(ram_we), 32'h0);
    chk({tag, "_ram_addr"}, ram_addr, 32'h0);
    chk({tag, "_ram_wdata"}, ram_wdata, 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  logic        rf, rl, rwe;
  logic [31:0] rfa, rla, rwd;

  initial begin
    // Reset with both requesters active: everything must stay at zero.
    reset_n = 1'b0;
    drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h200, 32'hFFFF_FFFF);
    #3;
    check_zero("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("rst1");
    idle();
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Lone fetch read.
    drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_cycle();
    idle();
    repeat (LAT + 1) do_cycle();

    // Contention: L wins until the streak limit, then F once.
    drive(1'b1, 32'h180, 1'b0, 1'b1, 1'b0, 32'h200, 32'h0);
    repeat (6) do_cycle();
    idle();
    repeat (LAT + 1) do_cycle();

    // Store against a waiting fetch, then the fetch.
    drive(1'b1, 32'h1C0, 1'b0, 1'b1, 1'b1, 32'h300, 32'h1234_5678);
    do_cycle();
    drive(1'b1, 32'h1C0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_cycle();
    idle();
    repeat (LAT + 1) do_cycle();

    // Flush kills two in-flight fetches but keeps the same-cycle fetch.
    drive(1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_cycle();
    drive(1'b1, 32'h108, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_cycle();
    drive(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    do_cycle();
    idle();
    repeat (LAT + 2) do_cycle();

    // Mixed F, L load, F back-to-back.
    drive(1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h600, 32'h0);
    do_cycle();
    drive(1'b1, 32'h504, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_cycle();
    idle();
    repeat (LAT + 1) do_cycle();

    // Random traffic; each requester holds its request until granted.
    rf = 1'b0; rl = 1'b0; rwe = 1'b0; rfa = 32'h0; rla = 32'h0; rwd = 32'h0;
    for (int k = 0; k < 400; k++) begin
      if (!rf || last_fg) begin
        rf  = ($urandom_range(0, 3) != 0);
        rfa = 32'($urandom_range(0, 1023)) << 2;
      end
      if (!rl || last_lg) begin
        rl  = ($urandom_range(0, 2) != 0);
        rwe = ($urandom_range(0, 2) == 0);
        rla = 32'h1_0000 | (32'($urandom_range(0, 1023)) << 2);
        rwd = $urandom;
      end
      drive(rf, rfa, ($urandom_range(0, 9) == 0), rl, rwe, rla, rwd);
      last_fg = 1'b0;
      last_lg = 1'b0;
      do_cycle();
    end
    idle();
    repeat (LAT + 1) do_cycle();

    // Reset asserted mid-cycle with two reads in flight.
    drive(1'b1, 32'h700, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    do_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h800, 32'h0);
    do_cycle();
    drive(1'b1, 32'h900, 1'b0, 1'b1, 1'b0, 32'h904, 32'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("rstmid0");
    @(negedge clk);
    check_zero("rstmid1");
    @(posedge clk);
    #1;
    check_zero("rstmid2");
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    streak = 0;
    @(posedge clk);
    #1;
    repeat (LAT + 2) do_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single RAM port of the execution core between two requesters: instruction fetch (requester F) and the load/store path (requester L).
- Sits between the fetch/LSU logic and the RAM interface (ram_en/addr/data).
- Arbitrates one access per cycle, tracks in-flight reads through a fixed-latency pipeline and routes read data back to the requester that issued it.
- Supports a fetch flush that discards stale instruction reads after a PC redirect.

Parameters:
- RD_LATENCY, 1, RAM read latency in cycles from accepted request to valid ram_rdata (1..4).
- MAX_L_STREAK, 4, consecutive L grants allowed while F is waiting before F is forced a grant (1..15).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch read request
- f_addr  in  32  fetch address (word aligned)
- f_gnt  out  1  fetch request accepted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  32  fetch read data
- f_flush  in  1  discard all in-flight fetch reads
- l_req  in  1  load/store request
- l_we  in  1  1 = store, 0 = load
- l_addr  in  32  load/store address
- l_wdata  in  32  store data
- l_gnt  out  1  load/store request accepted this cycle
- l_rvalid  out  1  load data valid
- l_rdata  out  32  load data
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write enable
- ram_addr  out  32  RAM address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid RD_LATENCY cycles after a read strobe
- busy  out  1  any read in flight

Behaviour:
- Reset (async assert, sync release): streak counter = 0, in-flight pipeline cleared. All outputs 0 while reset_n is low, including gnt, rvalid, ram_en and busy.
- Grant is combinational in the request cycle. A requester must hold req/addr/data stable until gnt. An access is accepted when req && gnt.
- Priority: L wins by default. F wins when l_req=0, or when streak == MAX_L_STREAK and f_req=1.
- Exactly one of f_gnt/l_gnt is high per cycle, or neither.
- ram_en = f_gnt | l_gnt. ram_addr, ram_we and ram_wdata are muxed from the granted requester.
  - On an F grant: ram_we = 0.
  - When idle: ram_addr/ram_wdata = 0 and ram_we = 0.
- Streak counter update, per clock:
  - L granted and f_req=1: streak += 1, saturating at MAX_L_STREAK.
  - F granted, or f_req=0: streak = 0.
- In-flight tracking: a RD_LATENCY-deep shift register of {valid, owner}.
  - Stage 0 loads valid = (gnt && read), owner = F or L.
  - Stores insert valid = 0.
  - The output stage asserts the owner's rvalid for exactly 1 cycle. The owner's rdata = ram_rdata; the non-owner's rdata = 0.
- Read latency: rvalid is seen in cycle N + RD_LATENCY for an accept in cycle N. Throughput is 1 access per cycle; back-to-back reads return in order.
- f_flush: clears valid on every in-flight entry with owner F, including any stage reaching the output this cycle, so f_rvalid = 0 that cycle.
  - A fetch granted in the same cycle as f_flush is still issued and returned; it is the post-redirect fetch.
  - L entries are never affected.
- busy = OR of all in-flight valid bits.
- Simultaneous f_req and l_req with streak < MAX_L_STREAK: l_gnt = 1, f_gnt = 0.
- An L store and an earlier-issued L load in flight: the load data returns unaffected by ordering; the RAM is responsible for its own read/write ordering.
- Reset mid-operation: in-flight reads are dropped and no rvalid is produced after reset release for pre-reset requests.

Test Plan:
- Only f_req=1, f_addr=0x100, ram_rdata=0xDEADBEEF at issue+1 (RD_LATENCY=1) -> f_gnt=1 in cycle 0; f_rvalid=1, f_rdata=0xDEADBEEF in cycle 1; l_rvalid=0.
- f_req and l_req (load, 0x200) held high for 6 cycles, MAX_L_STREAK=4 -> grants L,L,L,L,F,L; streak returns to 0 after the F grant.
- l_req store 0x300/0x12345678 back-to-back with f_req -> ram_we=1, ram_addr=0x300, ram_wdata=0x12345678 in the L cycle; no l_rvalid for the store; F granted next cycle.
- RD_LATENCY=3, F reads at cycles 0 and 1, f_flush=1 in cycle 2 with a new F read at 0x400 -> no f_rvalid in cycles 3 and 4; f_rvalid for 0x400 in cycle 5.
- Mixed stream F,L(load),F at RD_LATENCY=2 -> rvalids appear in the same order (f, l, f) with correct owner routing and data.
- reset_n pulsed low mid-cycle with 2 reads in flight -> all outputs go 0 immediately; no rvalid after release; busy = 0.
